clock_divider_ctrl: RTL and testbench

CLOCK_DIVIDER_CTRL -- requirements
Module: clock_divider_ctrl

---
 rtl/clock_divider_ctrl.sv | 118 +++++++++++
 tb/tb_clock_divider_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_ctrl.sv
// rtl/clock_divider_ctrl.sv - programmable 50%-duty clock divider with glitch-free half-period update
module clock_divider_ctrl #(
    parameter int W            = 16,
    parameter int DEFAULT_HALF = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic         i_cfg_valid,
    input  logic [W-1:0] i_cfg_half,
    output logic         o_cfg_ready,
    output logic         o_cfg_error,
    output logic         o_clk,
    output logic         o_tick,
    output logic         o_busy,
    output logic [W-1:0] o_half
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

    localparam logic [W-1:0] DEF_HALF = W'(DEFAULT_HALF);
    localparam logic [W-1:0] ONE      = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] half_q, half_d;
    logic [W-1:0] pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic         err_q, err_d;

    logic running, wrap, xfer, xfer_zero, xfer_load;

    always_comb begin
        running   = (state_q != S_IDLE);
        wrap      = running && (cnt_q == half_q - ONE);
        xfer      = i_cfg_valid && o_cfg_ready;
        xfer_zero = xfer && (i_cfg_half == '0);
        xfer_load = xfer && (i_cfg_half != '0);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a dropped enable always wins over a request or a wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_enable) state_d = S_RUN;
            S_RUN: begin
                if (!i_enable)                state_d = S_IDLE;
                else if (xfer_load && !wrap)  state_d = S_PEND;
            end
            S_PEND: begin
                if (!i_enable)  state_d = S_IDLE;
                else if (wrap)  state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_cfg_ready = !i_reset && (state_q != S_PEND);
        o_busy      = (state_q == S_PEND);
    end

    // H only moves at a phase boundary so no shortened o_clk phase is produced
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        half_d = half_q;
        pend_d = pend_q;
        err_d  = xfer_zero;
        if (!running) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (xfer_load) half_d = i_cfg_half;
        end else if (!i_enable || wrap) begin
            cnt_d  = '0;
            clk_d  = i_enable ? ~clk_q : 1'b0;
            tick_d = i_enable;
            if (state_q == S_PEND) half_d = pend_q;
            else if (xfer_load)    half_d = i_cfg_half;
        end else begin
            cnt_d = cnt_q + ONE;
            if (xfer_load) pend_d = i_cfg_half;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= '0;
            half_q <= DEF_HALF;
            pend_q <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign o_clk       = clk_q;
    assign o_tick      = tick_q;
    assign o_cfg_error = err_q;
    assign o_half      = half_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb/tb_clock_divider_ctrl.sv - directed self-checking bench for clock_divider_ctrl
module tb_clock_divider_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         i_reset, i_enable, i_cfg_valid;
    logic [W-1:0] i_cfg_half;
    logic         o_cfg_ready, o_cfg_error, o_clk, o_tick, o_busy;
    logic [W-1:0] o_half;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    clock_divider_ctrl #(.W(W), .DEFAULT_HALF(32)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_cfg_valid (i_cfg_valid),
        .i_cfg_half  (i_cfg_half),
        .o_cfg_ready (o_cfg_ready),
        .o_cfg_error (o_cfg_error),
        .o_clk       (o_clk),
        .o_tick      (o_tick),
        .o_busy      (o_busy),
        .o_half      (o_half)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles until the next o_tick, bounded so a dead divider still reaches the summary
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!o_tick && n < 300);
    endtask

    int n;

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_cfg_valid = 1'b0; i_cfg_half = '0;
        cyc(2);
        chk("rst_clk",   32'(o_clk), 0);
        chk("rst_tick",  32'(o_tick), 0);
        chk("rst_err",   32'(o_cfg_error), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_ready", 32'(o_cfg_ready), 0);
        chk("rst_half",  32'(o_half), 32);

        i_reset = 1'b0;
        cyc(1);
        chk("idle_ready", 32'(o_cfg_ready), 1);

        // Default H=32: first tick, then 32/32 phases
        i_enable = 1'b1;
        wait_tick(n);
        chk("first_tick", 32'(n), 33);
        chk("first_clk",  32'(o_clk), 1);
        wait_tick(n);
        chk("high_phase", 32'(n), 32);
        chk("low_clk",    32'(o_clk), 0);
        wait_tick(n);
        chk("low_phase",  32'(n), 32);

        // Request 5 at cnt=10 is held until the wrap
        cyc(10);
        i_cfg_valid = 1'b1; i_cfg_half = 16'd5;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("pend_busy",  32'(o_busy), 1);
        chk("pend_ready", 32'(o_cfg_ready), 0);
        chk("pend_half",  32'(o_half), 32);
        wait_tick(n);
        chk("pend_wrap",  32'(n), 21);
        chk("h5_half",    32'(o_half), 5);
        chk("h5_busy",    32'(o_busy), 0);
        chk("h5_ready",   32'(o_cfg_ready), 1);
        wait_tick(n);
        chk("h5_phase_a", 32'(n), 5);
        wait_tick(n);
        chk("h5_phase_b", 32'(n), 5);

        // Move to H=4, then request 7 exactly on the wrap cycle
        i_cfg_valid = 1'b1; i_cfg_half = 16'd4;
        cyc(1);
        i_cfg_valid = 1'b0;
        wait_tick(n);
        chk("h4_load",    32'(n), 4);
        chk("h4_half",    32'(o_half), 4);
        cyc(3);
        i_cfg_valid = 1'b1; i_cfg_half = 16'd7;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("wrapreq_tick", 32'(o_tick), 1);
        chk("wrapreq_busy", 32'(o_busy), 0);
        chk("wrapreq_half", 32'(o_half), 7);
        wait_tick(n);
        chk("h7_phase",   32'(n), 7);

        // Zero request is rejected with a one-cycle error pulse
        cyc(2);
        i_cfg_valid = 1'b1; i_cfg_half = 16'd0;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("zero_err",   32'(o_cfg_error), 1);
        chk("zero_half",  32'(o_half), 7);
        chk("zero_busy",  32'(o_busy), 0);
        cyc(1);
        chk("zero_err_clr", 32'(o_cfg_error), 0);
        wait_tick(n);
        chk("zero_rest",  32'(n), 3);
        wait_tick(n);
        chk("zero_phase", 32'(n), 7);

        // Disable while pending P=3 adopts P immediately
        i_cfg_valid = 1'b1; i_cfg_half = 16'd3;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("p3_busy",    32'(o_busy), 1);
        i_enable = 1'b0;
        cyc(1);
        chk("dis_busy",   32'(o_busy), 0);
        chk("dis_clk",    32'(o_clk), 0);
        chk("dis_tick",   32'(o_tick), 0);
        chk("dis_half",   32'(o_half), 3);
        chk("dis_ready",  32'(o_cfg_ready), 1);
        cyc(2);
        chk("idle_clk",   32'(o_clk), 0);
        i_enable = 1'b1;
        wait_tick(n);
        chk("h3_first",   32'(n), 4);
        wait_tick(n);
        chk("h3_high",    32'(n), 3);
        wait_tick(n);
        chk("h3_low",     32'(n), 3);

        // Request together with disable: state goes IDLE, H still loads
        i_enable = 1'b0; i_cfg_valid = 1'b1; i_cfg_half = 16'd9;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("both_half",  32'(o_half), 9);
        chk("both_clk",   32'(o_clk), 0);
        chk("both_busy",  32'(o_busy), 0);

        // Reset in PEND discards P
        i_enable = 1'b1;
        cyc(3);
        i_cfg_valid = 1'b1; i_cfg_half = 16'd2;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("rp_busy",    32'(o_busy), 1);
        i_reset = 1'b1;
        cyc(1);
        chk("rp_busy0",   32'(o_busy), 0);
        chk("rp_ready",   32'(o_cfg_ready), 0);
        chk("rp_half",    32'(o_half), 32);
        chk("rp_clk",     32'(o_clk), 0);
        chk("rp_tick",    32'(o_tick), 0);
        chk("rp_err",     32'(o_cfg_error), 0);

        // H=1: tick every cycle, o_clk toggling every cycle
        i_reset = 1'b0; i_enable = 1'b0; i_cfg_valid = 1'b1; i_cfg_half = 16'd1;
        cyc(1);
        i_cfg_valid = 1'b0;
        chk("h1_half",    32'(o_half), 1);
        i_enable = 1'b1;
        cyc(2);
        for (int k = 0; k < 6; k++) begin
            chk("h1_tick", 32'(o_tick), 1);
            chk("h1_clk",  32'(o_clk), (k % 2 == 0) ? 1 : 0);
            cyc(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
